key_search_scheduler: RTL

Dispatches candidate RC4 secret keys to a bank of parallel decrypt/check cores and collects their verdicts. It replaces single-core key stepping with a round-robin scheduler. It owns the key counter, hands each idle core the next untried key with a one-cycle start pulse, frees cores on their done pulse, and latches the first successful key. It sits between the top-level control (start, LEDs) and the replicated cracking cores.

---
 rtl/key_search_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/key_search_scheduler.sv
// Round-robin dispatcher handing ascending RC4 candidate keys to a bank of
// decrypt/check cores, collecting verdicts and latching the first winning key.
module key_search_scheduler #(
  parameter int                 NUM_CORES = 4,
  parameter int                 KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH:0] KEY_LIMIT = 25'h0400000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_success,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           busy,
  output logic                           found,
  output logic                           exhausted,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [9:0]                     LEDR
);
  localparam int                 PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [KEY_WIDTH:0] KEY_ONE = {{KEY_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_FOUND     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_t;

  state_t                         state_r, state_s;
  logic [KEY_WIDTH:0]             next_key_r, next_key_s;
  logic [PTR_W-1:0]               rr_ptr_r, rr_ptr_s;
  logic [NUM_CORES-1:0]           slot_busy_r, slot_busy_s;
  logic [NUM_CORES-1:0]           core_start_r, launch_s;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_r;
  logic                           busy_r, busy_s;
  logic                           found_r, found_s;
  logic                           exhausted_r, exhausted_s;
  logic [KEY_WIDTH-1:0]           found_key_r, found_key_s;
  logic                           pick_ok_s;
  logic [NUM_CORES-1:0]           pick_oh_s;
  logic [PTR_W-1:0]               pick_nxt_s;
  logic [NUM_CORES-1:0]           win_s;
  logic                           win_any_s;
  logic [KEY_WIDTH-1:0]           win_key_s;

  // Done pulses from idle slots carry no verdict
  assign win_s = core_done & core_success & slot_busy_r;

  // Round-robin choice of the first idle slot at or after rr_ptr, then wrapping
  always_comb begin
    pick_ok_s  = 1'b0;
    pick_oh_s  = '0;
    pick_nxt_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!pick_ok_s && !slot_busy_r[i] && (i >= int'(rr_ptr_r))) begin
        pick_ok_s    = 1'b1;
        pick_oh_s[i] = 1'b1;
        pick_nxt_s   = PTR_W'((i + 1) % NUM_CORES);
      end else begin
        pick_ok_s = pick_ok_s;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!pick_ok_s && !slot_busy_r[i]) begin
        pick_ok_s    = 1'b1;
        pick_oh_s[i] = 1'b1;
        pick_nxt_s   = PTR_W'((i + 1) % NUM_CORES);
      end else begin
        pick_ok_s = pick_ok_s;
      end
    end
  end

  // Lowest-index successful core wins when several report together
  always_comb begin
    win_any_s = 1'b0;
    win_key_s = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (win_s[i]) begin
        win_any_s = 1'b1;
        win_key_s = core_key_r[i*KEY_WIDTH +: KEY_WIDTH];
      end else begin
        win_any_s = win_any_s;
      end
    end
  end

  // Next-state, dispatch and verdict logic
  always_comb begin
    state_s     = state_r;
    next_key_s  = next_key_r;
    rr_ptr_s    = rr_ptr_r;
    launch_s    = '0;
    found_s     = found_r;
    exhausted_s = exhausted_r;
    found_key_s = found_key_r;
    slot_busy_s = slot_busy_r & ~core_done;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (win_any_s) begin
          state_s     = ST_FOUND;
          found_s     = 1'b1;
          found_key_s = win_key_s;
        end else if (next_key_r >= KEY_LIMIT) begin
          state_s = ST_DRAIN;
        end else if (pick_ok_s) begin
          launch_s   = pick_oh_s;
          next_key_s = next_key_r + KEY_ONE;
          rr_ptr_s   = pick_nxt_s;
          if (next_key_s >= KEY_LIMIT) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (win_any_s) begin
          state_s     = ST_FOUND;
          found_s     = 1'b1;
          found_key_s = win_key_s;
        end else if (slot_busy_s == '0) begin
          state_s     = ST_EXHAUSTED;
          exhausted_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FOUND:     state_s = ST_FOUND;
      ST_EXHAUSTED: state_s = ST_EXHAUSTED;
      default:      state_s = ST_IDLE;
    endcase
    slot_busy_s = slot_busy_s | launch_s;
    busy_s      = (state_s == ST_RUN) || (state_s == ST_DRAIN);
  end

  // State, key counter, slot occupancy and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      next_key_r   <= '0;
      rr_ptr_r     <= '0;
      slot_busy_r  <= '0;
      core_start_r <= '0;
      core_key_r   <= '0;
      busy_r       <= 1'b0;
      found_r      <= 1'b0;
      exhausted_r  <= 1'b0;
      found_key_r  <= '0;
    end else begin
      state_r      <= state_s;
      next_key_r   <= next_key_s;
      rr_ptr_r     <= rr_ptr_s;
      slot_busy_r  <= slot_busy_s;
      core_start_r <= launch_s;
      busy_r       <= busy_s;
      found_r      <= found_s;
      exhausted_r  <= exhausted_s;
      found_key_r  <= found_key_s;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (launch_s[i]) begin
          core_key_r[i*KEY_WIDTH +: KEY_WIDTH] <= next_key_r[KEY_WIDTH-1:0];
        end
      end
    end
  end

  assign core_start = core_start_r;
  assign core_key   = core_key_r;
  assign busy       = busy_r;
  assign found      = found_r;
  assign exhausted  = exhausted_r;
  assign found_key  = found_key_r;
  assign LEDR       = {7'd0, exhausted_r, found_r, busy_r};
endmodule
